// File: rtl/apb_rr_arbiter.sv
// Two-master round-robin arbiter in front of a single APB slave.
// Optional APB_TIMEOUT_EN aborts ACCESS phases that never see PREADY.
module apb_rr_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              M0_PSEL,
    input  logic              M0_PENABLE,
    input  logic              M0_PWRITE,
    input  logic [ADDR_W-1:0] M0_PADDR,
    input  logic [DATA_W-1:0] M0_PWDATA,
    output logic [DATA_W-1:0] M0_PRDATA,
    output logic              M0_PREADY,
    output logic              M0_PSLVERR,
    input  logic              M1_PSEL,
    input  logic              M1_PENABLE,
    input  logic              M1_PWRITE,
    input  logic [ADDR_W-1:0] M1_PADDR,
    input  logic [DATA_W-1:0] M1_PWDATA,
    output logic [DATA_W-1:0] M1_PRDATA,
    output logic              M1_PREADY,
    output logic              M1_PSLVERR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t state;
    logic   grant;
    logic   win;
    logic   req_any;
    logic   tmo_hit;
    logic   xfer_end;
    logic   resp_vld;
    logic   resp_err;
    logic   unused_penable;

    logic [DATA_W-1:0] resp_data;

    // Masters sequence their own PENABLE; the slave phase comes from our FSM.
    assign unused_penable = M0_PENABLE ^ M1_PENABLE;

    assign req_any = M0_PSEL | M1_PSEL;

    // grant holds the most recently granted master; a tie goes to the other.
    always_comb begin
        win = 1'b0;
        if (M0_PSEL && M1_PSEL) begin
            win = ~grant;
        end else if (M1_PSEL) begin
            win = 1'b1;
        end
    end

`ifdef APB_TIMEOUT_EN
    logic [8:0] tmo_cnt;

    assign tmo_hit = (state == ACCESS) && !PREADY &&
                     (tmo_cnt == 9'(TIMEOUT_CYC - 1));

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            tmo_cnt <= '0;
        end else if (state == SETUP) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS && !PREADY) begin
            tmo_cnt <= tmo_cnt + 9'd1;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = (TIMEOUT_CYC != 0);
    assign tmo_hit    = 1'b0;
`endif

    assign xfer_end = (state == ACCESS) && (PREADY || tmo_hit);

    // Nothing is returned in a cycle where reset is cancelling the transfer.
    assign resp_vld  = xfer_end && !HRESET;
    assign resp_err  = tmo_hit ? 1'b1 : PSLVERR;
    assign resp_data = tmo_hit ? '0 : PRDATA;

    assign M0_PREADY  = resp_vld && !grant && M0_PSEL;
    assign M1_PREADY  = resp_vld && grant && M1_PSEL;
    assign M0_PSLVERR = M0_PREADY && resp_err;
    assign M1_PSLVERR = M1_PREADY && resp_err;
    assign M0_PRDATA  = M0_PREADY ? resp_data : '0;
    assign M1_PRDATA  = M1_PREADY ? resp_data : '0;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= IDLE;
            grant   <= 1'b1;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_any) begin
                        grant  <= win;
                        PSEL   <= 1'b1;
                        PWRITE <= win ? M1_PWRITE : M0_PWRITE;
                        PADDR  <= win ? M1_PADDR : M0_PADDR;
                        PWDATA <= win ? M1_PWDATA : M0_PWDATA;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (xfer_end) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter; timeout scenario only when
// APB_TIMEOUT_EN is defined, otherwise an indefinite-wait scenario.
module tb_apb_rr_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 256;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          M0_PSEL, M0_PENABLE, M0_PWRITE;
    logic [AW-1:0] M0_PADDR;
    logic [DW-1:0] M0_PWDATA, M0_PRDATA;
    logic          M0_PREADY, M0_PSLVERR;
    logic          M1_PSEL, M1_PENABLE, M1_PWRITE;
    logic [AW-1:0] M1_PADDR;
    logic [DW-1:0] M1_PWDATA, M1_PRDATA;
    logic          M1_PREADY, M1_PSLVERR;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;

    int errors = 0;
    int checks = 0;

    apb_rr_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .M0_PSEL(M0_PSEL), .M0_PENABLE(M0_PENABLE), .M0_PWRITE(M0_PWRITE),
        .M0_PADDR(M0_PADDR), .M0_PWDATA(M0_PWDATA), .M0_PRDATA(M0_PRDATA),
        .M0_PREADY(M0_PREADY), .M0_PSLVERR(M0_PSLVERR),
        .M1_PSEL(M1_PSEL), .M1_PENABLE(M1_PENABLE), .M1_PWRITE(M1_PWRITE),
        .M1_PADDR(M1_PADDR), .M1_PWDATA(M1_PWDATA), .M1_PRDATA(M1_PRDATA),
        .M1_PREADY(M1_PREADY), .M1_PSLVERR(M1_PSLVERR),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        M0_PSEL = 0; M0_PENABLE = 0; M0_PWRITE = 0; M0_PADDR = '0; M0_PWDATA = '0;
        M1_PSEL = 0; M1_PENABLE = 0; M1_PWRITE = 0; M1_PADDR = '0; M1_PWDATA = '0;
        PRDATA = '0; PREADY = 0; PSLVERR = 0;
    endtask

    task automatic do_reset();
        HRESET = 1;
        idle_inputs();
        step();
        step();
        HRESET = 0;
    endtask

    task automatic test_reset();
        HRESET = 1;
        idle_inputs();
        M0_PSEL = 1; M0_PADDR = 32'h55; PREADY = 1; PSLVERR = 1;
        PRDATA = 32'hFFFF_FFFF;
        step();
        step();
        #2;
        if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin
            errors++; $display("FAIL rst_ctl got=%b exp=000", {PSEL, PENABLE, PWRITE});
        end
        checks++;
        if ({PADDR, PWDATA} !== 64'h0) begin
            errors++; $display("FAIL rst_addr_data got=%h exp=0", {PADDR, PWDATA});
        end
        checks++;
        if ({M0_PREADY, M0_PSLVERR, M1_PREADY, M1_PSLVERR} !== 4'b0000) begin
            errors++; $display("FAIL rst_resp got=%b exp=0000",
                {M0_PREADY, M0_PSLVERR, M1_PREADY, M1_PSLVERR});
        end
        checks++;
        if ({M0_PRDATA, M1_PRDATA} !== 64'h0) begin
            errors++; $display("FAIL rst_prdata got=%h exp=0", {M0_PRDATA, M1_PRDATA});
        end
        checks++;
        HRESET = 0;
        idle_inputs();
        step();
    endtask

    task automatic test_write_single();
        do_reset();
        M0_PSEL = 1; M0_PWRITE = 1; M0_PADDR = 32'h10; M0_PWDATA = 32'hCAFE;
        PREADY = 1;
        #2;
        if ({PSEL, M0_PREADY} !== 2'b00) begin
            errors++; $display("FAIL wr_cycN got=%b exp=00", {PSEL, M0_PREADY});
        end
        checks++;
        step();
        M0_PENABLE = 1;
        #2;
        if ({PSEL, PENABLE, PWRITE, M0_PREADY} !== 4'b1010) begin
            errors++; $display("FAIL wr_setup got=%b exp=1010",
                {PSEL, PENABLE, PWRITE, M0_PREADY});
        end
        checks++;
        if (PADDR !== 32'h10 || PWDATA !== 32'hCAFE) begin
            errors++; $display("FAIL wr_setup_bus got=%h/%h exp=10/cafe", PADDR, PWDATA);
        end
        checks++;
        step();
        #2;
        if ({PSEL, PENABLE, M0_PREADY, M1_PREADY} !== 4'b1110) begin
            errors++; $display("FAIL wr_access got=%b exp=1110",
                {PSEL, PENABLE, M0_PREADY, M1_PREADY});
        end
        checks++;
        if (PADDR !== 32'h10) begin
            errors++; $display("FAIL wr_access_addr got=%h exp=10", PADDR);
        end
        checks++;
        step();
        M0_PSEL = 0; M0_PENABLE = 0;
        #2;
        if ({PSEL, PENABLE, M0_PREADY} !== 3'b000) begin
            errors++; $display("FAIL wr_idle got=%b exp=000", {PSEL, PENABLE, M0_PREADY});
        end
        checks++;
    endtask

    task automatic test_round_robin();
        do_reset();
        PREADY = 1;
        M0_PSEL = 1; M0_PADDR = 32'h20;
        M1_PSEL = 1; M1_PADDR = 32'h30;
        step();
        #2;
        if (PADDR !== 32'h20) begin
            errors++; $display("FAIL rr_first got=%h exp=20", PADDR);
        end
        checks++;
        step();
        #2;
        if ({M0_PREADY, M1_PREADY} !== 2'b10) begin
            errors++; $display("FAIL rr_first_resp got=%b exp=10", {M0_PREADY, M1_PREADY});
        end
        checks++;
        step();
        M0_PSEL = 0;
        step();
        #2;
        if (PADDR !== 32'h30 || PSEL !== 1'b1) begin
            errors++; $display("FAIL rr_second got=%h/%b exp=30/1", PADDR, PSEL);
        end
        checks++;
        step();
        #2;
        if ({M0_PREADY, M1_PREADY} !== 2'b01) begin
            errors++; $display("FAIL rr_second_resp got=%b exp=01", {M0_PREADY, M1_PREADY});
        end
        checks++;
        step();
        M0_PSEL = 1; M0_PADDR = 32'h24;
        M1_PSEL = 1; M1_PADDR = 32'h34;
        step();
        #2;
        if (PADDR !== 32'h24) begin
            errors++; $display("FAIL rr_third got=%h exp=24", PADDR);
        end
        checks++;
        step();
        #2;
        if ({M0_PREADY, M1_PREADY} !== 2'b10) begin
            errors++; $display("FAIL rr_third_resp got=%b exp=10", {M0_PREADY, M1_PREADY});
        end
        checks++;
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_wait_read();
        do_reset();
        PRDATA = 32'h1234;
        M1_PSEL = 1; M1_PWRITE = 0; M1_PADDR = 32'h44;
        step();
        M1_PENABLE = 1;
        M0_PSEL = 1; M0_PWRITE = 1; M0_PADDR = 32'h50;
        #2;
        if (PADDR !== 32'h44 || PWRITE !== 1'b0) begin
            errors++; $display("FAIL rd_setup got=%h/%b exp=44/0", PADDR, PWRITE);
        end
        checks++;
        for (int i = 1; i <= 5; i++) begin
            step();
            #2;
            if ({PENABLE, M1_PREADY, M0_PREADY} !== 3'b100 || M1_PRDATA !== 32'h0) begin
                errors++; $display("FAIL rd_wait%0d got=%b/%h exp=100/0",
                    i, {PENABLE, M1_PREADY, M0_PREADY}, M1_PRDATA);
            end
            checks++;
        end
        step();
        PREADY = 1;
        #2;
        if ({M1_PREADY, M0_PREADY} !== 2'b10 || M1_PRDATA !== 32'h1234) begin
            errors++; $display("FAIL rd_done got=%b/%h exp=10/1234",
                {M1_PREADY, M0_PREADY}, M1_PRDATA);
        end
        checks++;
        if (M0_PRDATA !== 32'h0) begin
            errors++; $display("FAIL rd_m0_data got=%h exp=0", M0_PRDATA);
        end
        checks++;
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_slverr();
        do_reset();
        PREADY = 1; PSLVERR = 1;
        M1_PSEL = 1; M1_PWRITE = 1; M1_PADDR = 32'h60;
        step();
        #2;
        if (M1_PSLVERR !== 1'b0) begin
            errors++; $display("FAIL err_setup got=%b exp=0", M1_PSLVERR);
        end
        checks++;
        step();
        #2;
        if ({M1_PREADY, M1_PSLVERR, M0_PSLVERR} !== 3'b110) begin
            errors++; $display("FAIL err_access got=%b exp=110",
                {M1_PREADY, M1_PSLVERR, M0_PSLVERR});
        end
        checks++;
        step();
        M1_PSEL = 0;
        #2;
        if (M1_PSLVERR !== 1'b0) begin
            errors++; $display("FAIL err_after got=%b exp=0", M1_PSLVERR);
        end
        checks++;
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        M0_PSEL = 1; M0_PADDR = 32'h70;
        step();
        step();
        HRESET = 1;
        #2;
        if ({PSEL, PENABLE, M0_PREADY} !== 3'b110) begin
            errors++; $display("FAIL rstmid_access got=%b exp=110",
                {PSEL, PENABLE, M0_PREADY});
        end
        checks++;
        step();
        HRESET = 0;
        M0_PSEL = 1; M0_PADDR = 32'h74;
        M1_PSEL = 1; M1_PADDR = 32'h78;
        #2;
        if ({PSEL, PENABLE} !== 2'b00) begin
            errors++; $display("FAIL rstmid_drop got=%b exp=00", {PSEL, PENABLE});
        end
        checks++;
        step();
        #2;
        if (PADDR !== 32'h74 || PSEL !== 1'b1) begin
            errors++; $display("FAIL rstmid_regrant got=%h/%b exp=74/1", PADDR, PSEL);
        end
        checks++;
        step();
        PREADY = 1;
        #2;
        if ({M0_PREADY, M1_PREADY} !== 2'b10) begin
            errors++; $display("FAIL rstmid_resp got=%b exp=10", {M0_PREADY, M1_PREADY});
        end
        checks++;
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_abandon();
        do_reset();
        M1_PSEL = 1; M1_PADDR = 32'h80;
        step();
        step();
        M1_PSEL = 0;
        step();
        PREADY = 1;
        #2;
        if ({PSEL, PENABLE, M1_PREADY} !== 3'b110) begin
            errors++; $display("FAIL abandon_resp got=%b exp=110",
                {PSEL, PENABLE, M1_PREADY});
        end
        checks++;
        step();
        #2;
        if (PSEL !== 1'b0) begin
            errors++; $display("FAIL abandon_end got=%b exp=0", PSEL);
        end
        checks++;
        idle_inputs();
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        do_reset();
        PRDATA = 32'hBEEF;
        M0_PSEL = 1; M0_PADDR = 32'h90;
        step();
        n = 0;
        for (int i = 1; i <= TMO + 8; i++) begin
            step();
            #2;
            if (M0_PREADY === 1'b1 && n == 0) begin
                n = i;
                if ({M0_PSLVERR, M0_PRDATA} !== {1'b1, 32'h0}) begin
                    errors++; $display("FAIL tmo_resp got=%b/%h exp=1/0",
                        M0_PSLVERR, M0_PRDATA);
                end
                checks++;
            end
            if (n != 0) break;
        end
        if (n != TMO) begin
            errors++; $display("FAIL tmo_cycle got=%0d exp=%0d", n, TMO);
        end
        checks++;
        step();
        M0_PSEL = 0;
        #2;
        if ({PSEL, PENABLE} !== 2'b00) begin
            errors++; $display("FAIL tmo_drop got=%b exp=00", {PSEL, PENABLE});
        end
        checks++;
        idle_inputs();
        step();
    endtask
`else
    task automatic test_no_timeout();
        do_reset();
        PRDATA = 32'hBEEF;
        M0_PSEL = 1; M0_PADDR = 32'h90;
        step();
        repeat (TMO + 20) step();
        #2;
        if ({PSEL, PENABLE, M0_PREADY} !== 3'b110) begin
            errors++; $display("FAIL notmo_hold got=%b exp=110",
                {PSEL, PENABLE, M0_PREADY});
        end
        checks++;
        PREADY = 1;
        #1;
        if ({M0_PREADY, M0_PSLVERR, M0_PRDATA} !== {2'b10, 32'hBEEF}) begin
            errors++; $display("FAIL notmo_done got=%b/%h exp=10/beef",
                {M0_PREADY, M0_PSLVERR}, M0_PRDATA);
        end
        checks++;
        step();
        idle_inputs();
        step();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_single();
        test_round_robin();
        test_wait_read();
        test_slverr();
        test_reset_mid();
        test_abandon();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
